// File: rtl/if0_pc_gen_pkg.sv
// rtl/if0_pc_gen_pkg.sv - shared types and constants for the IF0 PC generator
package if0_pc_gen_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam int unsigned FETCH_BYTES          = 8;

  // One next-line-predictor result for a single fetch slot
  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  bim;
  } nlp_pred_t;

  // SEQ: normal fetch; DS_WAIT: fetching the delay slot of a slot-1 branch
  typedef enum logic {
    SEQ     = 1'b0,
    DS_WAIT = 1'b1
  } if0_state_e;

  // Address of the packet following the one containing pc (wraps mod 2^32)
  function automatic logic [31:0] next_packet(input logic [31:0] pc);
    next_packet = (pc & ~32'(FETCH_BYTES - 1)) + 32'(FETCH_BYTES);
  endfunction

endpackage

// File: rtl/if0_next_pc_sel.sv
// rtl/if0_next_pc_sel.sv - combinational next-PC priority mux; predictions enabled by IF0_NLP_EN
module if0_next_pc_sel
  import if0_pc_gen_pkg::*;
(
  input  logic [31:0] pc_q,
  input  if0_state_e  state_q,
  input  logic [31:0] saved_target_q,
  input  nlp_pred_t   pred0,
  input  nlp_pred_t   pred1,
  input  logic        bk_redirect_valid,
  input  logic [31:0] bk_redirect_pc,
  input  logic        if3_redirect_valid,
  input  logic [31:0] if3_redirect_pc,
  input  logic        if1_ready,
  output logic [31:0] pc_d,
  output if0_state_e  state_d,
  output logic [31:0] saved_target_d,
  output logic [1:0]  slot_mask,
  output logic [1:0]  pred_slot,
  output logic [31:0] pred_target
);

  logic [31:0] seq_pc;
  logic        eff0;
  logic        eff1;
  logic        unused_bim;

  assign seq_pc     = next_packet(pc_q);
  // A delay-slot packet only carries slot 0; otherwise slot 0 is valid when pc is 8-aligned
  assign slot_mask  = (state_q == DS_WAIT) ? 2'b01 : {1'b1, ~pc_q[2]};
  assign unused_bim = ^{pred0.bim, pred1.bim};

`ifdef IF0_NLP_EN
  assign eff0 = (state_q == SEQ) && slot_mask[0] && pred0.valid && pred0.taken;
  assign eff1 = (state_q == SEQ) && slot_mask[1] && pred1.valid && pred1.taken;
`else
  logic unused_pred;
  assign unused_pred = ^{pred0, pred1};
  assign eff0 = 1'b0;
  assign eff1 = 1'b0;
`endif

  // Priority select: redirects, stall, delay-slot release, slot-0 branch, slot-1 branch, sequential
  always_comb begin
    pc_d           = pc_q;
    state_d        = state_q;
    saved_target_d = saved_target_q;
    pred_slot      = 2'b00;
    pred_target    = 32'h0;
    if (bk_redirect_valid) begin
      pc_d    = bk_redirect_pc;
      state_d = SEQ;
    end else if (if3_redirect_valid) begin
      pc_d    = if3_redirect_pc;
      state_d = SEQ;
    end else if (!if1_ready) begin
      pc_d = pc_q;
    end else if (state_q == DS_WAIT) begin
      pc_d    = saved_target_q;
      state_d = SEQ;
    end else if (eff0) begin
      // Slot 1 of this packet is the delay slot, so jump straight to the target
      pc_d        = pred0.target;
      pred_slot   = 2'b01;
      pred_target = pred0.target;
    end else if (eff1) begin
      // Delay slot lives in the next packet; park the target until it is fetched
      pc_d           = seq_pc;
      saved_target_d = pred1.target;
      state_d        = DS_WAIT;
      pred_slot      = 2'b10;
      pred_target    = pred1.target;
    end else begin
      pc_d = seq_pc;
    end
  end

endmodule

// File: rtl/if0_pc_gen.sv
// rtl/if0_pc_gen.sv - fetch-stage-0 PC generator with delay-slot handling; NLP prediction via IF0_NLP_EN
module if0_pc_gen
  import if0_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred0_valid,
  input  logic        pred0_taken,
  input  logic [31:0] pred0_target,
  input  logic [1:0]  pred0_bim,
  input  logic        pred1_valid,
  input  logic        pred1_taken,
  input  logic [31:0] pred1_target,
  input  logic [1:0]  pred1_bim,
  input  logic        bk_redirect_valid,
  input  logic [31:0] bk_redirect_pc,
  input  logic        if3_redirect_valid,
  input  logic [31:0] if3_redirect_pc,
  input  logic        if1_ready,
  output logic [31:0] pc,
  output logic        out_valid,
  output logic [1:0]  slot_mask,
  output logic [1:0]  pred_slot,
  output logic [31:0] pred_target,
  output logic [3:0]  pred_bim
);

  logic [31:0] pc_q, pc_d;
  if0_state_e  state_q, state_d;
  logic [31:0] saved_target_q, saved_target_d;
  nlp_pred_t   pred0, pred1;

  assign pred0 = '{valid: pred0_valid, taken: pred0_taken, target: pred0_target, bim: pred0_bim};
  assign pred1 = '{valid: pred1_valid, taken: pred1_taken, target: pred1_target, bim: pred1_bim};

  assign pc        = pc_q;
  assign out_valid = !bk_redirect_valid && !if3_redirect_valid;
  assign pred_bim  = {pred1_bim, pred0_bim};

  if0_next_pc_sel u_sel (
    .pc_q               (pc_q),
    .state_q            (state_q),
    .saved_target_q     (saved_target_q),
    .pred0              (pred0),
    .pred1              (pred1),
    .bk_redirect_valid  (bk_redirect_valid),
    .bk_redirect_pc     (bk_redirect_pc),
    .if3_redirect_valid (if3_redirect_valid),
    .if3_redirect_pc    (if3_redirect_pc),
    .if1_ready          (if1_ready),
    .pc_d               (pc_d),
    .state_d            (state_d),
    .saved_target_d     (saved_target_d),
    .slot_mask          (slot_mask),
    .pred_slot          (pred_slot),
    .pred_target        (pred_target)
  );

  // Fetch PC, delay-slot state and parked slot-1 target
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_VECTOR;
      state_q        <= SEQ;
      saved_target_q <= 32'h0;
    end else begin
      pc_q           <= pc_d;
      state_q        <= state_d;
      saved_target_q <= saved_target_d;
    end
  end

endmodule

// File: tb/tb_if0_pc_gen.sv
// tb/tb_if0_pc_gen.sv - directed self-checking bench for if0_pc_gen
module tb_if0_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred0_valid, pred0_taken, pred1_valid, pred1_taken;
  logic [31:0] pred0_target, pred1_target;
  logic [1:0]  pred0_bim, pred1_bim;
  logic        bk_redirect_valid, if3_redirect_valid, if1_ready;
  logic [31:0] bk_redirect_pc, if3_redirect_pc;
  logic [31:0] pc;
  logic        out_valid;
  logic [1:0]  slot_mask, pred_slot;
  logic [31:0] pred_target;
  logic [3:0]  pred_bim;

  int passed = 0;
  int total  = 0;

  if0_pc_gen dut (
    .clk(clk), .rst(rst),
    .pred0_valid(pred0_valid), .pred0_taken(pred0_taken), .pred0_target(pred0_target), .pred0_bim(pred0_bim),
    .pred1_valid(pred1_valid), .pred1_taken(pred1_taken), .pred1_target(pred1_target), .pred1_bim(pred1_bim),
    .bk_redirect_valid(bk_redirect_valid), .bk_redirect_pc(bk_redirect_pc),
    .if3_redirect_valid(if3_redirect_valid), .if3_redirect_pc(if3_redirect_pc),
    .if1_ready(if1_ready),
    .pc(pc), .out_valid(out_valid), .slot_mask(slot_mask), .pred_slot(pred_slot),
    .pred_target(pred_target), .pred_bim(pred_bim)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred0_valid = 0; pred0_taken = 0; pred0_target = 0; pred0_bim = 0;
    pred1_valid = 0; pred1_taken = 0; pred1_target = 0; pred1_bim = 0;
    bk_redirect_valid = 0; bk_redirect_pc = 0;
    if3_redirect_valid = 0; if3_redirect_pc = 0;
    if1_ready = 1;
  endtask

  task automatic jump(input logic [31:0] target);
    bk_redirect_valid = 1; bk_redirect_pc = target;
    tick();
    bk_redirect_valid = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    tick(); tick();
    rst = 0;
    #1;
    total++; if (pc !== 32'hBFC0_0000) $display("FAIL reset_pc got %h want bfc00000", pc); else passed++;
    total++; if (slot_mask !== 2'b11) $display("FAIL reset_mask got %b want 11", slot_mask); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL reset_valid got %b want 1", out_valid); else passed++;
    total++; if (pred_slot !== 2'b00) $display("FAIL reset_pred_slot got %b want 00", pred_slot); else passed++;
    total++; if (pred_target !== 32'h0) $display("FAIL reset_pred_target got %h want 0", pred_target); else passed++;
  endtask

  task automatic test_sequential();
    tick();
    total++; if (pc !== 32'hBFC0_0008) $display("FAIL seq_pc1 got %h want bfc00008", pc); else passed++;
    total++; if (slot_mask !== 2'b11) $display("FAIL seq_mask1 got %b want 11", slot_mask); else passed++;
    tick();
    total++; if (pc !== 32'hBFC0_0010) $display("FAIL seq_pc2 got %h want bfc00010", pc); else passed++;
  endtask

  task automatic test_redirects();
    bk_redirect_valid = 1; bk_redirect_pc = 32'h8000_0004;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL bk_kill got %b want 0", out_valid); else passed++;
    tick();
    bk_redirect_valid = 0;
    #1;
    total++; if (pc !== 32'h8000_0004) $display("FAIL bk_pc got %h want 80000004", pc); else passed++;
    total++; if (slot_mask !== 2'b10) $display("FAIL odd_mask got %b want 10", slot_mask); else passed++;
    tick();
    total++; if (pc !== 32'h8000_0008) $display("FAIL odd_next got %h want 80000008", pc); else passed++;
    if3_redirect_valid = 1; if3_redirect_pc = 32'h0000_1000;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL if3_kill got %b want 0", out_valid); else passed++;
    tick();
    if3_redirect_valid = 0;
    #1;
    total++; if (pc !== 32'h0000_1000) $display("FAIL if3_pc got %h want 00001000", pc); else passed++;
    bk_redirect_valid = 1; bk_redirect_pc = 32'h0000_3000;
    if3_redirect_valid = 1; if3_redirect_pc = 32'h0000_5000;
    tick();
    idle();
    #1;
    total++; if (pc !== 32'h0000_3000) $display("FAIL both_pc got %h want 00003000", pc); else passed++;
  endtask

  task automatic test_stall();
    if1_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc !== 32'h0000_3000) $display("FAIL stall_pc%0d got %h want 00003000", i, pc); else passed++;
    end
    bk_redirect_valid = 1; bk_redirect_pc = 32'h0000_4000;
    tick();
    idle();
    #1;
    total++; if (pc !== 32'h0000_4000) $display("FAIL stall_redirect got %h want 00004000", pc); else passed++;
    tick();
    total++; if (pc !== 32'h0000_4008) $display("FAIL release_pc got %h want 00004008", pc); else passed++;
  endtask

  task automatic test_wrap();
    jump(32'hFFFF_FFFC);
    total++; if (slot_mask !== 2'b10) $display("FAIL wrap_mask got %b want 10", slot_mask); else passed++;
    tick();
    total++; if (pc !== 32'h0) $display("FAIL wrap_pc got %h want 00000000", pc); else passed++;
    total++; if (slot_mask !== 2'b11) $display("FAIL wrap_mask2 got %b want 11", slot_mask); else passed++;
    pred0_bim = 2'b01; pred1_bim = 2'b10;
    #1;
    total++; if (pred_bim !== 4'b1001) $display("FAIL bim got %b want 1001", pred_bim); else passed++;
    idle();
  endtask

`ifdef IF0_NLP_EN
  task automatic test_pred0();
    jump(32'h8000_0000);
    pred0_valid = 1; pred0_taken = 1; pred0_target = 32'h8000_1004;
    #1;
    total++; if (pred_slot !== 2'b01) $display("FAIL p0_slot got %b want 01", pred_slot); else passed++;
    total++; if (pred_target !== 32'h8000_1004) $display("FAIL p0_target got %h want 80001004", pred_target); else passed++;
    tick();
    total++; if (pc !== 32'h8000_1004) $display("FAIL p0_pc got %h want 80001004", pc); else passed++;
    total++; if (slot_mask !== 2'b10) $display("FAIL p0_mask got %b want 10", slot_mask); else passed++;
    total++; if (pred_slot !== 2'b00) $display("FAIL p0_masked got %b want 00", pred_slot); else passed++;
    idle();
  endtask

  task automatic test_pred1();
    jump(32'h8000_0000);
    pred1_valid = 1; pred1_taken = 1; pred1_target = 32'h8000_2000;
    #1;
    total++; if (pred_slot !== 2'b10) $display("FAIL p1_slot got %b want 10", pred_slot); else passed++;
    total++; if (pred_target !== 32'h8000_2000) $display("FAIL p1_target got %h want 80002000", pred_target); else passed++;
    tick();
    idle();
    pred0_valid = 1; pred0_taken = 1; pred0_target = 32'h9000_0000;
    #1;
    total++; if (pc !== 32'h8000_0008) $display("FAIL ds_pc got %h want 80000008", pc); else passed++;
    total++; if (slot_mask !== 2'b01) $display("FAIL ds_mask got %b want 01", slot_mask); else passed++;
    total++; if (pred_slot !== 2'b00) $display("FAIL ds_pred_ignored got %b want 00", pred_slot); else passed++;
    idle();
    if1_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc !== 32'h8000_0008 || slot_mask !== 2'b01)
        $display("FAIL ds_stall%0d got %h/%b want 80000008/01", i, pc, slot_mask); else passed++;
    end
    if1_ready = 1;
    tick();
    total++; if (pc !== 32'h8000_2000) $display("FAIL ds_release got %h want 80002000", pc); else passed++;
    total++; if (slot_mask !== 2'b11) $display("FAIL ds_seq_mask got %b want 11", slot_mask); else passed++;
  endtask

  task automatic test_ds_redirect();
    jump(32'h8000_0000);
    pred1_valid = 1; pred1_taken = 1; pred1_target = 32'h8000_2000;
    tick();
    idle();
    bk_redirect_valid = 1; bk_redirect_pc = 32'h8000_3000;
    if3_redirect_valid = 1; if3_redirect_pc = 32'h8000_5000;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL dsr_kill got %b want 0", out_valid); else passed++;
    tick();
    idle();
    #1;
    total++; if (pc !== 32'h8000_3000 || slot_mask !== 2'b11)
      $display("FAIL dsr_pc got %h/%b want 80003000/11", pc, slot_mask); else passed++;
    tick();
    total++; if (pc !== 32'h8000_3008) $display("FAIL dsr_discard got %h want 80003008", pc); else passed++;
    jump(32'h8000_0000);
    pred1_valid = 1; pred1_taken = 1; pred1_target = 32'h8000_2000;
    tick();
    idle();
    rst = 1;
    tick();
    rst = 0;
    #1;
    total++; if (pc !== 32'hBFC0_0000 || slot_mask !== 2'b11)
      $display("FAIL ds_reset got %h/%b want bfc00000/11", pc, slot_mask); else passed++;
    tick();
    total++; if (pc !== 32'hBFC0_0008) $display("FAIL ds_reset_seq got %h want bfc00008", pc); else passed++;
  endtask
`else
  task automatic test_no_nlp();
    jump(32'h8000_0000);
    pred0_valid = 1; pred0_taken = 1; pred0_target = 32'h8000_1004;
    #1;
    total++; if (pred_slot !== 2'b00) $display("FAIL nonlp_slot got %b want 00", pred_slot); else passed++;
    total++; if (pred_target !== 32'h0) $display("FAIL nonlp_target got %h want 0", pred_target); else passed++;
    tick();
    total++; if (pc !== 32'h8000_0008) $display("FAIL nonlp_pc got %h want 80000008", pc); else passed++;
    idle();
    pred1_valid = 1; pred1_taken = 1; pred1_target = 32'h8000_2000;
    tick();
    total++; if (pc !== 32'h8000_0010 || slot_mask !== 2'b11)
      $display("FAIL nonlp_p1 got %h/%b want 80000010/11", pc, slot_mask); else passed++;
    idle();
    tick();
    total++; if (pc !== 32'h8000_0018) $display("FAIL nonlp_seq got %h want 80000018", pc); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_redirects();
    test_stall();
    test_wrap();
`ifdef IF0_NLP_EN
    test_pred0();
    test_pred1();
    test_ds_redirect();
`else
    test_no_nlp();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if0_pc_gen.md
# if0_pc_gen

Fetch-stage-0 PC generator. Holds the fetch PC, presents it to the next-line predictor and IF1, and computes the next fetch PC each cycle from IF1 backpressure, backend/IF3 redirects and NLP predictions. It implements MIPS delay-slot semantics for 2-instruction, 8-byte-aligned fetch packets. It sits directly downstream of the NLP lookup and upstream of IF1.

## Interface
Parameters:
- RESET_VECTOR, 32'hBFC0_0000, first fetch PC after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pred0_valid / pred0_taken  in  1 / 1  NLP hit and taken for slot 0 (pc & ~4).
- pred0_target  in  32  slot 0 predicted target.
- pred0_bim  in  2  slot 0 BIM state.
- pred1_valid / pred1_taken / pred1_target / pred1_bim  in  1/1/32/2  same fields for slot 1 (pc | 4).
- bk_redirect_valid, bk_redirect_pc  in  1, 32  backend redirect (mispredict/exception).
- if3_redirect_valid, if3_redirect_pc  in  1, 32  IF3 predecode redirect.
- if1_ready  in  1  IF1 accepts the packet this cycle.
- pc  out  32  current fetch PC; also drives the NLP lookup.
- out_valid  out  1  packet valid to IF1.
- slot_mask  out  2  per-slot valid (bit0 = slot 0).
- pred_slot  out  2  one-hot slot predicted taken (0 if none).
- pred_target  out  32  predicted target of pred_slot.
- pred_bim  out  4  {pred1_bim, pred0_bim} forwarded for IF3 update.

## Operation
- Registers: pc_q, state (SEQ, DS_WAIT), saved_target (32).
- The packet base is pc_q & ~7, and seq = base + 8.
- slot_mask: SEQ gives {1, ~pc_q[2]}. A DS_WAIT packet gives 2'b01, meaning only the delay slot is valid.
- Effective predictions: a slot counts only if its mask bit is set, pred*_valid is high and pred*_taken is high. The lowest taken slot wins.
- out_valid = !bk_redirect_valid && !if3_redirect_valid.
- Next-PC priority, highest first:
  1. bk_redirect: pc_q ← bk_redirect_pc, state ← SEQ. Applied regardless of if1_ready.
  2. if3_redirect: pc_q ← if3_redirect_pc, state ← SEQ. Applied regardless of if1_ready.
  3. !if1_ready: hold pc_q, state and saved_target.
  4. state DS_WAIT and accepted: pc_q ← saved_target, state ← SEQ.
  5. Slot 0 predicted taken: its delay slot is slot 1 of the same packet, so pc_q ← pred0_target and slot_mask stays as computed.
  6. Slot 1 predicted taken: its delay slot is in the next packet, so pc_q ← seq, saved_target ← pred1_target, state ← DS_WAIT.
  7. Otherwise pc_q ← seq.
- In DS_WAIT, predictions are ignored and pred_slot = 0.
- pred_slot and pred_target reflect the rule that fired for the current packet. pred_target is 0 when pred_slot = 0.
- Redirect PCs are used verbatim. A redirect to an address with PC[2]=1 produces a slot-1-only packet.

## Timing
- Reset: pc_q = RESET_VECTOR, state = SEQ, saved_target = 0.
- Cycle after reset: out_valid = 1, slot_mask = 2'b11, pred_slot = 0, pred_target = 0.
- The NLP lookup is combinational on pc. Next-PC selection is combinational, and pc_q updates at posedge.
- Throughput is one packet per cycle. Redirect-to-fetch latency is 1 cycle, and the redirect cycle kills the current packet.
- Simultaneous backend and IF3 redirects: backend wins.
- A redirect during DS_WAIT discards saved_target.
- Reset during DS_WAIT returns to RESET_VECTOR/SEQ.
- Address arithmetic is 32-bit and wraps modulo 2^32: base 0xFFFF_FFF8 + 8 gives 0.

## Configuration
- IF0_NLP_EN defined: prediction rules 5 and 6 are active.
- IF0_NLP_EN undefined: pred* inputs are ignored, pred_slot = 0, pred_target = 0, DS_WAIT is unreachable, and fetch is sequential apart from redirects. pred_bim is still forwarded.

## Structure
- Shared package:
  - nlp_pred_t {valid, taken, target[31:0], bim[1:0]}
  - if0_state_e {SEQ, DS_WAIT}
  - RESET_VECTOR default
  - FETCH_BYTES = 8
- Sub-module: if0_next_pc_sel, a combinational priority mux for rules 1–7. if0_pc_gen holds the registers and the handshake.

## Test plan
- Reset, if1_ready = 1, no predictions → pc sequence 0xBFC00000, 0xBFC00008, 0xBFC00010 with slot_mask 11.
- pc = 0x80000000, pred0 taken to 0x80001004 → next pc 0x80001004 with slot_mask 10; pred_slot = 01 on the branch packet.
- pc = 0x80000000, pred1 taken to 0x80002000 → 0x80000008 (slot_mask 01, DS_WAIT), then 0x80002000 (SEQ).
- In DS_WAIT, bk_redirect to 0x80003000 with if3_redirect also high → out_valid = 0, next pc 0x80003000, state SEQ.
- if1_ready = 0 for 3 cycles in DS_WAIT → pc, slot_mask and state stable; release → 0x80002000.
- Build without IF0_NLP_EN, pred0 taken → sequential pc, pred_slot = 0.
